// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state enum and the default operand width.
package add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_if.sv
// Handshake bundle for the serial adder: operand side and result side.
// Ports: clk, rst_n; in_valid/in_ready, a, b, sub; out_valid/out_ready, sum, carry, overflow.
interface add_if #(
    parameter int WIDTH = add_pkg::DEF_WIDTH
) (
    input logic clk,
    input logic rst_n
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport DUT (
        input  clk, rst_n, in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry, overflow
    );

    modport TB (
        input  clk, rst_n, in_ready, out_valid, sum, carry, overflow,
        output in_valid, a, b, sub, out_ready
    );

endinterface

// File: rtl/serial_adder_fa.sv
// One-bit full adder used as the single arithmetic element of the serial adder.
// Ports: x, y, cin in; s (sum bit), cout (carry out) out.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = x ^ y;
    assign s    = p ^ cin;
    assign cout = (x & y) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, one bit per cycle LSB first, valid/ready on both sides.
// Ports: clk, rst_n, in_valid/in_ready, a, b, sub, out_valid/out_ready, sum, carry, overflow.
module serial_adder
    import add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_c;

    full_adder u_fa (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as a + ~b + 1: invert b, seed carry with 1.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                // Result bits enter at the MSB and walk down to their place.
                acc_d = acc_q >> 1;
                acc_d[WIDTH-1] = fa_s;
                c_d   = fa_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = acc_d;
                    carry_d = fa_c;
                    // c_q is the carry into the MSB on this final step.
                    ovf_d   = c_q ^ fa_c;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: vector table, corner sequences and random ops
// against an arithmetic reference model, for WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    import add_pkg::*;

    typedef struct {
        string      nm;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       o;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    add_if #(.WIDTH(8)) i8 (.clk(clk), .rst_n(rst_n));
    add_if #(.WIDTH(1)) i1 (.clk(clk), .rst_n(rst_n));

    serial_adder #(.WIDTH(8)) u8 (
        .clk       (i8.clk),
        .rst_n     (i8.rst_n),
        .in_valid  (i8.in_valid),
        .in_ready  (i8.in_ready),
        .a         (i8.a),
        .b         (i8.b),
        .sub       (i8.sub),
        .out_valid (i8.out_valid),
        .out_ready (i8.out_ready),
        .sum       (i8.sum),
        .carry     (i8.carry),
        .overflow  (i8.overflow)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk       (i1.clk),
        .rst_n     (i1.rst_n),
        .in_valid  (i1.in_valid),
        .in_ready  (i1.in_ready),
        .a         (i1.a),
        .b         (i1.b),
        .sub       (i1.sub),
        .out_valid (i1.out_valid),
        .out_ready (i1.out_ready),
        .sum       (i1.sum),
        .carry     (i1.carry),
        .overflow  (i1.overflow)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input longint a,
                                  input longint b, input bit s,
                                  output longint sm, output bit c,
                                  output bit o);
        longint one = 1;
        longint m   = (one << w) - 1;
        longint sa, sb, r;
        sm = (s ? (a - b) : (a + b)) & m;
        c  = s ? (a >= b) : (((a + b) >> w) != 0);
        sa = ((a >> (w - 1)) & 1) != 0 ? a - (one << w) : a;
        sb = ((b >> (w - 1)) & 1) != 0 ? b - (one << w) : b;
        r  = s ? (sa - sb) : (sa + sb);
        o  = (r > (one << (w - 1)) - 1) || (r < -(one << (w - 1)));
    endfunction

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic s, output logic [7:0] sm,
                        output logic c, output logic o, output int lat);
        int n = 0;
        @(negedge clk);
        while (!i8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w8 in_ready wait", 64'(n < 50), 64'd1);
        i8.in_valid = 1'b1;
        i8.a = a;
        i8.b = b;
        i8.sub = s;
        @(posedge clk);
        @(negedge clk);
        i8.in_valid = 1'b0;
        i8.a = 8'($urandom);
        i8.b = 8'($urandom);
        lat = 0;
        while (!i8.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        sm = i8.sum;
        c  = i8.carry;
        o  = i8.overflow;
        i8.out_ready = 1'b1;
        @(negedge clk);
        i8.out_ready = 1'b0;
        chk("w8 out_valid drop", 64'(i8.out_valid), 64'd0);
    endtask

    task automatic run1(input logic a, input logic b, input logic s,
                        output logic sm, output logic c, output logic o,
                        output int lat);
        int n = 0;
        @(negedge clk);
        while (!i1.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w1 in_ready wait", 64'(n < 50), 64'd1);
        i1.in_valid = 1'b1;
        i1.a = a;
        i1.b = b;
        i1.sub = s;
        @(posedge clk);
        @(negedge clk);
        i1.in_valid = 1'b0;
        lat = 0;
        while (!i1.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        sm = i1.sum;
        c  = i1.carry;
        o  = i1.overflow;
        i1.out_ready = 1'b1;
        @(negedge clk);
        i1.out_ready = 1'b0;
        chk("w1 out_valid drop", 64'(i1.out_valid), 64'd0);
    endtask

    task automatic rand8(input logic [7:0] a, input logic [7:0] b,
                         input logic s);
        logic [7:0] sm;
        logic c, o;
        int lat;
        longint es;
        bit ec, eo;
        run8(a, b, s, sm, c, o, lat);
        model(8, longint'(a), longint'(b), s, es, ec, eo);
        chk("w8 latency", 64'(lat), 64'd8);
        chk("w8 sum", 64'(sm), 64'(es));
        chk("w8 carry", 64'(c), 64'(ec));
        chk("w8 overflow", 64'(o), 64'(eo));
    endtask

    task automatic rand1(input logic a, input logic b, input logic s);
        logic sm, c, o;
        int lat;
        longint es;
        bit ec, eo;
        run1(a, b, s, sm, c, o, lat);
        model(1, longint'(a), longint'(b), s, es, ec, eo);
        chk("w1 latency", 64'(lat), 64'd1);
        chk("w1 sum", 64'(sm), 64'(es));
        chk("w1 carry", 64'(c), 64'(ec));
        chk("w1 overflow", 64'(o), 64'(eo));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[6];
        logic [7:0] sm;
        logic       c, o;
        int         lat;
        int         seen;
        bit         held;

        tbl[0] = '{"3+5",   8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0};
        tbl[1] = '{"FF+1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{"7F+1",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{"5-3",   8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[4] = '{"3-5",   8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[5] = '{"80-1",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

        i8.in_valid = 1'b0;
        i8.a = '0;
        i8.b = '0;
        i8.sub = 1'b0;
        i8.out_ready = 1'b0;
        i1.in_valid = 1'b0;
        i1.a = '0;
        i1.b = '0;
        i1.sub = 1'b0;
        i1.out_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst in_ready", 64'(i8.in_ready), 64'd1);
        chk("rst out_valid", 64'(i8.out_valid), 64'd0);
        chk("rst sum", 64'(i8.sum), 64'd0);
        chk("rst carry", 64'(i8.carry), 64'd0);
        chk("rst overflow", 64'(i8.overflow), 64'd0);
        chk("rst w1 out_valid", 64'(i1.out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].sub, sm, c, o, lat);
            chk({"vec ", tbl[i].nm, " lat"}, 64'(lat), 64'd8);
            chk({"vec ", tbl[i].nm, " sum"}, 64'(sm), 64'(tbl[i].s));
            chk({"vec ", tbl[i].nm, " carry"}, 64'(c), 64'(tbl[i].c));
            chk({"vec ", tbl[i].nm, " ovf"}, 64'(o), 64'(tbl[i].o));
        end

        // Hold result with out_ready low while a second operand waits.
        @(negedge clk);
        i8.in_valid = 1'b1;
        i8.a = 8'h11;
        i8.b = 8'h22;
        i8.sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i8.a = 8'h01;
        i8.b = 8'h01;
        lat = 0;
        while (!i8.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("hold lat", 64'(lat), 64'd8);
        for (int k = 0; k < 5; k++) begin
            chk("hold out_valid", 64'(i8.out_valid), 64'd1);
            chk("hold in_ready", 64'(i8.in_ready), 64'd0);
            chk("hold sum", 64'(i8.sum), 64'h33);
            @(negedge clk);
        end
        i8.out_ready = 1'b1;
        @(negedge clk);
        i8.out_ready = 1'b0;
        chk("hs out_valid", 64'(i8.out_valid), 64'd0);
        chk("hs in_ready", 64'(i8.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        i8.in_valid = 1'b0;
        held = 1'b1;
        lat = 0;
        while (!i8.out_valid && lat < 200) begin
            if (i8.sum !== 8'h33) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("retain sum in busy", 64'(held), 64'd1);
        chk("second lat", 64'(lat), 64'd8);
        chk("second sum", 64'(i8.sum), 64'h02);
        i8.out_ready = 1'b1;
        @(negedge clk);
        i8.out_ready = 1'b0;

        // Reset in the 4th BUSY cycle aborts the operation.
        @(negedge clk);
        i8.in_valid = 1'b1;
        i8.a = 8'h7F;
        i8.b = 8'h01;
        i8.sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(i8.out_valid), 64'd0);
        chk("abort in_ready", 64'(i8.in_ready), 64'd1);
        chk("abort sum", 64'(i8.sum), 64'd0);
        chk("abort carry", 64'(i8.carry), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (i8.out_valid) seen++;
        end
        chk("abort no result", 64'(seen), 64'd0);
        rand8(8'h7F, 8'h01, 1'b0);

        for (int k = 0; k < 40; k++) begin
            rand8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        for (int k = 0; k < 4; k++) begin
            logic [1:0] ab;
            logic s1, c1, o1;
            ab = 2'(k);
            run1(ab[1], ab[0], 1'b0, s1, c1, o1, lat);
            chk("w1 tbl lat", 64'(lat), 64'd1);
            chk("w1 tbl sum", 64'(s1), 64'(ab[1] ^ ab[0]));
            chk("w1 tbl carry", 64'(c1), 64'(ab[1] & ab[0]));
        end

        for (int k = 0; k < 12; k++) begin
            rand1(1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/sub presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 sub  input  1  0 = a+b, 1 = a-b.
REQ-009 out_valid  output  1  sum/carry/overflow valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 carry  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-013 overflow  output  1  two's-complement signed overflow.

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on an edge with in_valid && in_ready, latch a, b XOR {WIDTH{sub}}, carry register = sub, bit counter = 0; go to BUSY.
REQ-016 BUSY: each cycle compute exactly one bit, LSB first, through the full-adder sub-module; shift result bit into sum register; update carry register; increment counter.
REQ-017 After the WIDTH-th BUSY edge, go to DONE; out_valid SHALL rise exactly WIDTH cycles after the accepting edge.
REQ-018 overflow SHALL equal carry into MSB XOR carry out of MSB, captured on the final BUSY edge.
REQ-019 DONE: out_valid = 1; sum, carry and overflow held stable while out_ready = 0.
REQ-020 DONE with out_ready = 1: return to IDLE on that edge; out_valid deasserts the following cycle.
REQ-021 in_valid, a, b and sub SHALL be ignored in BUSY and DONE; no operand is lost or queued.
REQ-022 sum/carry/overflow SHALL retain their last values after DONE until the next result completes.
REQ-023 WIDTH = 1 SHALL behave as a single full-adder step with 1-cycle latency.
REQ-024 Counter width SHALL be $clog2(WIDTH+1); no counter wrap within an operation.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, in_ready = 1, out_valid = 0, sum = 0, carry = 0, overflow = 0, counter = 0.
REQ-026 Reset during BUSY or DONE SHALL abort the operation; no result is produced for it.
REQ-027 First operand is accepted no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-028 Package add_pkg SHALL hold the state enum type (IDLE, BUSY, DONE) and the default WIDTH constant.
REQ-029 Ports SHALL be bundled in interface add_if #(WIDTH) with modport DUT (inputs clk, rst_n, in_valid, a, b, sub, out_ready; outputs the rest) and modport TB (directions mirrored).
REQ-030 One sub-module full_adder (inputs x, y, cin; outputs s, cout) SHALL be instantiated once and reused every BUSY cycle.

Verification
REQ-031 WIDTH=8, a=0x03, b=0x05, sub=0 -> after 8 cycles sum=0x08, carry=0, overflow=0.
REQ-032 WIDTH=8, 0xFF+0x01 -> sum=0x00, carry=1, overflow=0; 0x7F+0x01 -> sum=0x80, carry=0, overflow=1.
REQ-033 WIDTH=8, sub=1: 0x05-0x03 -> sum=0x02, carry=1; 0x03-0x05 -> sum=0xFE, carry=0; 0x80-0x01 -> sum=0x7F, overflow=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> outputs unchanged, in_ready=0, second operand accepted only after the out_ready handshake.
REQ-035 Assert rst_n=0 on the 4th BUSY cycle -> out_valid=0, in_ready=1, sum=0 immediately; new operation then completes correctly.
REQ-036 WIDTH=1, all four (a,b) with sub=0 -> sum=a^b, carry=a&b, out_valid after 1 cycle.
